// File: rtl/sys_proto_pkg.sv
// Shared serial command protocol definitions: frame headers,
// command type encoding and per-type frame lengths.
package sys_proto_pkg;

  localparam logic [7:0] HDR_WR      = 8'hAA;
  localparam logic [7:0] HDR_RD      = 8'hBB;
  localparam logic [7:0] HDR_ALU     = 8'hCC;
  localparam logic [7:0] HDR_ALU_NOP = 8'hDD;

  typedef enum logic [1:0] {
    CMD_WR      = 2'd0,
    CMD_RD      = 2'd1,
    CMD_ALU     = 2'd2,
    CMD_ALU_NOP = 2'd3
  } cmd_type_e;

  localparam int LEN_WR      = 3;
  localparam int LEN_RD      = 2;
  localparam int LEN_ALU     = 4;
  localparam int LEN_ALU_NOP = 2;

  // Index of the final byte of a frame.
  function automatic logic [1:0] last_idx(cmd_type_e t);
    logic [1:0] r;
    r = 2'(LEN_RD - 1);
    unique case (t)
      CMD_WR:      r = 2'(LEN_WR - 1);
      CMD_RD:      r = 2'(LEN_RD - 1);
      CMD_ALU:     r = 2'(LEN_ALU - 1);
      CMD_ALU_NOP: r = 2'(LEN_ALU_NOP - 1);
      default:     r = 2'(LEN_RD - 1);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sys_host_ctrl.sv
// Host command initiator: serialises one command into a byte frame
// on UART TX, then collects the single reply byte from UART RX.
// Ports: CLK/RST; CMD_* request + CMD_BUSY; TX_* byte out with
// TX_BUSY flow control; RX_* byte in; RSP_DATA/RSP_VLD/RSP_TIMEOUT.
module sys_host_ctrl
  import sys_proto_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TMO_W          = 12
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VLD,
  input  logic [1:0] CMD_TYPE,
  input  logic [3:0] CMD_ADDR,
  input  logic [7:0] CMD_A,
  input  logic [7:0] CMD_B,
  input  logic [3:0] CMD_FUN,
  output logic       CMD_BUSY,
  output logic [7:0] TX_P_DATA,
  output logic       TX_D_VLD,
  input  logic       TX_BUSY,
  input  logic [7:0] RX_P_DATA,
  input  logic       RX_D_VLD,
  output logic [7:0] RSP_DATA,
  output logic       RSP_VLD,
  output logic       RSP_TIMEOUT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_HI,
    S_WAIT_LO,
    S_WAIT_RSP,
    S_DONE
  } state_e;

  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  cmd_type_e         typ_q;
  logic [3:0]        addr_q, fun_q;
  logic [7:0]        a_q, b_q;
  logic [1:0]        idx_q, idx_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [7:0]        frame_byte;
  logic              cap;

  logic       busy_d, txv_d, rspv_d, tmop_d;
  logic [7:0] txd_d, rspd_d;

  assign cap = (state_q == S_IDLE) && CMD_VLD;

  always_comb begin
    frame_byte = 8'h00;
    unique case (typ_q)
      CMD_WR: begin
        unique case (idx_q)
          2'd0:    frame_byte = HDR_WR;
          2'd1:    frame_byte = {4'b0, addr_q};
          default: frame_byte = a_q;
        endcase
      end
      CMD_RD: begin
        unique case (idx_q)
          2'd0:    frame_byte = HDR_RD;
          default: frame_byte = {4'b0, addr_q};
        endcase
      end
      CMD_ALU: begin
        unique case (idx_q)
          2'd0:    frame_byte = HDR_ALU;
          2'd1:    frame_byte = a_q;
          2'd2:    frame_byte = b_q;
          default: frame_byte = {4'b0, fun_q};
        endcase
      end
      default: begin
        unique case (idx_q)
          2'd0:    frame_byte = HDR_ALU_NOP;
          default: frame_byte = {4'b0, fun_q};
        endcase
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    busy_d  = CMD_BUSY;
    txd_d   = TX_P_DATA;
    txv_d   = 1'b0;
    rspd_d  = RSP_DATA;
    rspv_d  = 1'b0;
    tmop_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (CMD_VLD) begin
          state_d = S_SEND;
          idx_d   = 2'd0;
          busy_d  = 1'b1;
        end
      end
      S_SEND: begin
        if (!TX_BUSY) begin
          txd_d   = frame_byte;
          txv_d   = 1'b1;
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (TX_BUSY) state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!TX_BUSY) begin
          if (idx_q != last_idx(typ_q)) begin
            idx_d   = idx_q + 2'd1;
            state_d = S_SEND;
          end else if (typ_q == CMD_WR) begin
            state_d = S_DONE;
          end else begin
            tmo_d   = '0;
            state_d = S_WAIT_RSP;
          end
        end
      end
      S_WAIT_RSP: begin
        // A reply in the terminal-count cycle beats the timeout.
        if (RX_D_VLD) begin
          rspd_d  = RX_P_DATA;
          rspv_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          tmop_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DONE: begin
        rspd_d  = 8'h00;
        rspv_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      tmo_q       <= '0;
      typ_q       <= CMD_WR;
      addr_q      <= 4'h0;
      fun_q       <= 4'h0;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      CMD_BUSY    <= 1'b0;
      TX_P_DATA   <= 8'h00;
      TX_D_VLD    <= 1'b0;
      RSP_DATA    <= 8'h00;
      RSP_VLD     <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      CMD_BUSY    <= busy_d;
      TX_P_DATA   <= txd_d;
      TX_D_VLD    <= txv_d;
      RSP_DATA    <= rspd_d;
      RSP_VLD     <= rspv_d;
      RSP_TIMEOUT <= tmop_d;
      if (cap) begin
        typ_q  <= cmd_type_e'(CMD_TYPE);
        addr_q <= CMD_ADDR;
        fun_q  <= CMD_FUN;
        a_q    <= CMD_A;
        b_q    <= CMD_B;
      end
    end
  end

endmodule

// File: tb/tb_sys_host_ctrl.sv
// Directed table-driven bench for sys_host_ctrl with a UART TX
// busy model, RX reply driver and reset/stray-byte sequences.
module tb_sys_host_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CMD_VLD = 1'b0;
  logic [1:0] CMD_TYPE = 2'd0;
  logic [3:0] CMD_ADDR = 4'h0;
  logic [7:0] CMD_A = 8'h00;
  logic [7:0] CMD_B = 8'h00;
  logic [3:0] CMD_FUN = 4'h0;
  logic       CMD_BUSY;
  logic [7:0] TX_P_DATA;
  logic       TX_D_VLD;
  logic       TX_BUSY = 1'b0;
  logic [7:0] RX_P_DATA = 8'h00;
  logic       RX_D_VLD = 1'b0;
  logic [7:0] RSP_DATA;
  logic       RSP_VLD;
  logic       RSP_TIMEOUT;

  sys_host_ctrl #(.TIMEOUT_CYCLES(16), .TMO_W(4)) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VLD(CMD_VLD), .CMD_TYPE(CMD_TYPE),
    .CMD_ADDR(CMD_ADDR), .CMD_A(CMD_A),
    .CMD_B(CMD_B), .CMD_FUN(CMD_FUN),
    .CMD_BUSY(CMD_BUSY),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .TX_BUSY(TX_BUSY),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RSP_DATA(RSP_DATA), .RSP_VLD(RSP_VLD),
    .RSP_TIMEOUT(RSP_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    else
      n_pass++;
  endtask

  // TX busy model: rises 3 clocks after a strobe, holds 10 clocks.
  bit   model_busy = 1'b0;
  int   fall_cyc   = 0;
  logic [7:0] txq[$];
  logic prev_v = 1'b0;

  initial begin
    forever begin
      @(negedge CLK);
      if (TX_D_VLD) begin
        model_busy = 1'b1;
        repeat (3) @(negedge CLK);
        TX_BUSY = 1'b1;
        repeat (10) @(negedge CLK);
        TX_BUSY = 1'b0;
        fall_cyc = cyc;
        model_busy = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (TX_D_VLD) begin
        txq.push_back(TX_P_DATA);
        chk("strobe_width", {31'd0, prev_v}, 32'd0);
      end
      prev_v = TX_D_VLD;
    end
  end

  typedef struct {
    logic [1:0]  typ;
    logic [3:0]  addr;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  fun;
    int          rep;   // 0 none, 1 early, 2 terminal-count
    logic [7:0]  reply;
    int          n;
    logic [31:0] bytes;
    logic [7:0]  exp_data;
    bit          exp_tmo;
    int          lat;
    bit          mid;
  } vec_t;

  vec_t vecs[6];

  task automatic run(input vec_t v, input string tag);
    bit got;
    bit known;
    int t0;
    logic [7:0] b;
    txq.delete();
    got = 1'b0;
    known = 1'b0;
    t0 = 0;
    @(negedge CLK);
    CMD_TYPE = v.typ;
    CMD_ADDR = v.addr;
    CMD_A    = v.a;
    CMD_B    = v.b;
    CMD_FUN  = v.fun;
    CMD_VLD  = 1'b1;
    @(negedge CLK);
    CMD_VLD  = 1'b0;
    CMD_TYPE = ~v.typ;
    CMD_ADDR = ~v.addr;
    CMD_A    = ~v.a;
    CMD_B    = ~v.b;
    CMD_FUN  = ~v.fun;
    chk({tag, "_busy"}, {31'd0, CMD_BUSY}, 32'd1);
    chk({tag, "_pre_strobe"}, {31'd0, TX_D_VLD}, 32'd0);
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge CLK);
      RX_D_VLD = 1'b0;
      CMD_VLD  = 1'b0;
      if (i == 0)
        chk({tag, "_hdr_lat"}, {31'd0, TX_D_VLD}, 32'd1);
      if (v.mid && i == 5) begin
        CMD_TYPE = 2'd0;
        CMD_VLD  = 1'b1;
      end
      if (RSP_VLD || RSP_TIMEOUT) begin
        got = 1'b1;
        chk({tag, "_tmo"}, {31'd0, RSP_TIMEOUT},
            {31'd0, v.exp_tmo});
        chk({tag, "_vld"}, {31'd0, RSP_VLD},
            {31'd0, !v.exp_tmo});
        if (!v.exp_tmo)
          chk({tag, "_data"}, {24'd0, RSP_DATA},
              {24'd0, v.exp_data});
        chk({tag, "_lat"}, cyc, t0 + v.lat);
        chk({tag, "_busy_low"}, {31'd0, CMD_BUSY}, 32'd0);
        if (v.rep == 1) begin
          RX_P_DATA = 8'h55;
          RX_D_VLD  = 1'b1;
        end
      end else begin
        if (!known && txq.size() == v.n && !model_busy) begin
          known = 1'b1;
          t0 = fall_cyc;
        end
        if (known &&
            ((v.rep == 1 && cyc == t0 + 3) ||
             (v.rep == 2 && cyc == t0 + 16))) begin
          RX_P_DATA = v.reply;
          RX_D_VLD  = 1'b1;
        end
      end
    end
    chk({tag, "_rsp_seen"}, {31'd0, got}, 32'd1);
    @(negedge CLK);
    RX_D_VLD = 1'b0;
    chk({tag, "_pulse_w"}, {30'd0, RSP_VLD, RSP_TIMEOUT}, 32'd0);
    repeat (3) @(negedge CLK);
    if (!v.exp_tmo)
      chk({tag, "_hold"}, {24'd0, RSP_DATA}, {24'd0, v.exp_data});
    chk({tag, "_idle"}, {31'd0, CMD_BUSY}, 32'd0);
    chk({tag, "_nbytes"}, txq.size(), v.n);
    for (int j = 0; j < v.n; j++) begin
      b = (j < txq.size()) ? txq[j] : 8'hxx;
      chk({tag, "_byte"}, {24'd0, b},
          {24'd0, v.bytes[31 - 8*j -: 8]});
    end
  endtask

  initial begin
    vecs[0] = '{2'd0, 4'h4, 8'h5A, 8'h00, 4'h0, 0, 8'h00,
                3, 32'hAA045A00, 8'h00, 1'b0, 2, 1'b0};
    vecs[1] = '{2'd1, 4'h2, 8'h00, 8'h00, 4'h0, 1, 8'h81,
                2, 32'hBB020000, 8'h81, 1'b0, 4, 1'b0};
    vecs[2] = '{2'd2, 4'h0, 8'h10, 8'h03, 4'h1, 1, 8'h13,
                4, 32'hCC100301, 8'h13, 1'b0, 4, 1'b1};
    vecs[3] = '{2'd3, 4'h0, 8'h00, 8'h00, 4'h2, 0, 8'h00,
                2, 32'hDD020000, 8'h00, 1'b1, 17, 1'b0};
    vecs[4] = '{2'd1, 4'hF, 8'h00, 8'h00, 4'h0, 2, 8'h3C,
                2, 32'hBB0F0000, 8'h3C, 1'b0, 17, 1'b0};
    vecs[5] = '{2'd3, 4'h0, 8'h00, 8'h00, 4'hF, 1, 8'h7E,
                2, 32'hDD0F0000, 8'h7E, 1'b0, 4, 1'b0};

    #3;
    chk("reset_outs",
        {12'd0, CMD_BUSY, TX_P_DATA, TX_D_VLD,
         RSP_DATA, RSP_VLD, RSP_TIMEOUT}, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    for (int k = 0; k < 6; k++)
      run(vecs[k], $sformatf("v%0d", k));

    // Stray reply byte while idle must not disturb RSP_DATA.
    @(negedge CLK);
    RX_P_DATA = 8'hEE;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
    repeat (2) @(negedge CLK);
    chk("stray_rx", {24'd0, RSP_DATA}, 32'h7E);
    chk("stray_vld", {31'd0, RSP_VLD}, 32'd0);

    // Reset during the second byte of a write.
    txq.delete();
    CMD_TYPE = 2'd0;
    CMD_ADDR = 4'h9;
    CMD_A    = 8'hC3;
    CMD_VLD  = 1'b1;
    @(negedge CLK);
    CMD_VLD  = 1'b0;
    for (int i = 0; i < 200 && txq.size() < 2; i++)
      @(negedge CLK);
    chk("rst_second_byte", txq.size(), 2);
    #2;
    RST = 1'b1;
    #1;
    chk("rst_async_outs",
        {12'd0, CMD_BUSY, TX_P_DATA, TX_D_VLD,
         RSP_DATA, RSP_VLD, RSP_TIMEOUT}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 100 && model_busy; i++)
      @(negedge CLK);
    chk("rst_quiet", {30'd0, TX_D_VLD, RSP_VLD}, 32'd0);
    run(vecs[1], "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
